// File: rtl/poly_note_synth.sv
// poly_note_synth
// Polyphonic note synthesiser: NUM_VOICES note-driven phase accumulators are
// time-multiplexed over one external wave-table ROM and summed into one
// unsigned mixed sample per sample_tick.
// Build option: define POLY_SYNTH_ENVELOPE_EN to add a per-voice 8-bit
// attack/release gain; without it every sounding voice plays at unity gain.
module poly_note_synth #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 16,
    parameter int TABLE_AW   = 8,
    parameter int AMP_W      = 8,
    localparam int VW        = $clog2(NUM_VOICES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic                note_wr,
    input  logic [VW-1:0]       note_voice,
    input  logic [9:0]          note_data,
    input  logic [1:0]          wave_sel,
    output logic [TABLE_AW-1:0] rom_addr,
    input  logic [AMP_W-1:0]    rom_data,
    output logic [AMP_W+VW-1:0] mix_out,
    output logic                mix_valid,
    output logic                busy
);

    localparam int               MW     = AMP_W + VW;
    localparam logic [AMP_W-1:0] MID    = {1'b1, {(AMP_W-1){1'b0}}};
    localparam logic [VW-1:0]    LAST_V = VW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ACCUM,
        OUTPUT
    } state_t;

    // Sequencer state
    state_t              state_q, state_d;
    logic [VW-1:0]       voice_q, voice_d;
    logic [MW-1:0]       acc_q, acc_d;
    logic [AMP_W-1:0]    cap_top_q, cap_top_d;
    logic [TABLE_AW-1:0] rom_addr_q, rom_addr_d;
    logic [MW-1:0]       mix_out_q, mix_out_d;
    logic                mix_valid_q, mix_valid_d;

    // Per-voice state
    logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]    phase_d [NUM_VOICES];
    logic [PHASE_W-1:0]    inc_q   [NUM_VOICES];
    logic [PHASE_W-1:0]    inc_d   [NUM_VOICES];
    logic [NUM_VOICES-1:0] key_q, key_d;
`ifdef POLY_SYNTH_ENVELOPE_EN
    logic [7:0]            gain_q  [NUM_VOICES];
    logic [7:0]            gain_d  [NUM_VOICES];
`endif

    logic [NUM_VOICES-1:0] sounding;
    logic [AMP_W-1:0]      wave_s;
    logic [AMP_W-1:0]      tri_fold;
    logic [AMP_W-1:0]      contrib;

    // Note word decode
    logic                  note_act;
    logic [6:0]            note_base;
    logic [PHASE_W-1:0]    note_inc;
    logic                  note_unused;

    // Base phase increment of each semitone at octave 0
    function automatic logic [6:0] base_inc(input logic [3:0] semi);
        case (semi)
            4'd0:    base_inc = 7'd64;
            4'd1:    base_inc = 7'd68;
            4'd2:    base_inc = 7'd72;
            4'd3:    base_inc = 7'd76;
            4'd4:    base_inc = 7'd81;
            4'd5:    base_inc = 7'd85;
            4'd6:    base_inc = 7'd91;
            4'd7:    base_inc = 7'd96;
            4'd8:    base_inc = 7'd102;
            4'd9:    base_inc = 7'd108;
            4'd10:   base_inc = 7'd114;
            4'd11:   base_inc = 7'd121;
            default: base_inc = 7'd0;
        endcase
    endfunction

    assign note_base   = base_inc(note_data[3:0]);
    assign note_act    = note_data[9] && (note_data[3:0] <= 4'd11);
    assign note_inc    = {{(PHASE_W-7){1'b0}}, note_base} << note_data[6:4];
    assign note_unused = ^note_data[8:7];

`ifdef POLY_SYNTH_ENVELOPE_EN
    // A voice keeps sounding after key-off until its release gain has decayed to zero
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            sounding[i] = key_q[i] || (gain_q[i] != 8'd0);
        end
    end
`else
    assign sounding = key_q;
`endif

    // Generate the selected waveform from the phase captured at fetch time
    always_comb begin
        tri_fold = {cap_top_q[AMP_W-2:0], 1'b0};
        wave_s   = rom_data;
        case (wave_sel)
            2'd0:    wave_s = rom_data;
            2'd1:    wave_s = cap_top_q[AMP_W-1] ? '0 : '1;
            2'd2:    wave_s = cap_top_q;
            default: wave_s = cap_top_q[AMP_W-1] ? ~tri_fold : tri_fold;
        endcase
    end

`ifdef POLY_SYNTH_ENVELOPE_EN
    logic signed [AMP_W:0]   env_diff;
    logic signed [AMP_W+9:0] env_prod;

    // Scale the waveform around mid-scale by the voice gain; silent voices sit at mid-scale
    always_comb begin
        env_diff = $signed({1'b0, wave_s}) - $signed({1'b0, MID});
        env_prod = (AMP_W+10)'(env_diff) * (AMP_W+10)'($signed({1'b0, gain_q[voice_q]}));
        contrib  = MID;
        if (sounding[voice_q]) begin
            contrib = MID + AMP_W'(env_prod >>> 8);
        end
    end
`else
    // Sounding voices contribute the raw waveform; silent voices sit at mid-scale
    always_comb begin
        contrib = MID;
        if (sounding[voice_q]) begin
            contrib = wave_s;
        end
    end
`endif

    // Sequencer next state plus per-voice updates; a note write overrides any same-cycle phase step
    always_comb begin
        state_d     = state_q;
        voice_d     = voice_q;
        acc_d       = acc_q;
        cap_top_d   = cap_top_q;
        rom_addr_d  = rom_addr_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        phase_d     = phase_q;
        inc_d       = inc_q;
        key_d       = key_q;
`ifdef POLY_SYNTH_ENVELOPE_EN
        gain_d      = gain_q;
`endif

        case (state_q)
            IDLE: begin
                acc_d   = '0;
                voice_d = '0;
                if (sample_tick) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rom_addr_d = phase_q[voice_q][PHASE_W-1 -: TABLE_AW];
                cap_top_d  = phase_q[voice_q][PHASE_W-1 -: AMP_W];
                state_d    = ACCUM;
            end
            ACCUM: begin
                acc_d = acc_q + {{VW{1'b0}}, contrib};
                if (sounding[voice_q]) begin
                    phase_d[voice_q] = phase_q[voice_q] + inc_q[voice_q];
                end
                voice_d = voice_q + 1'b1;
                state_d = (voice_q == LAST_V) ? OUTPUT : FETCH;
            end
            OUTPUT: begin
                mix_out_d   = acc_q;
                mix_valid_d = 1'b1;
                state_d     = IDLE;
`ifdef POLY_SYNTH_ENVELOPE_EN
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (key_q[i]) begin
                        if (gain_q[i] != 8'hFF) begin
                            gain_d[i] = gain_q[i] + 8'd1;
                        end
                    end else if (gain_q[i] != 8'd0) begin
                        gain_d[i] = gain_q[i] - 8'd1;
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (note_wr) begin
            if (note_act) begin
                if (sounding[note_voice]) begin
                    phase_d[note_voice] = phase_q[note_voice];
                end else begin
                    phase_d[note_voice] = '0;
                end
                inc_d[note_voice] = note_inc;
                key_d[note_voice] = 1'b1;
`ifdef POLY_SYNTH_ENVELOPE_EN
                if (!key_q[note_voice]) begin
                    gain_d[note_voice] = 8'd0;
                end
`endif
            end else begin
                phase_d[note_voice] = phase_q[note_voice];
                key_d[note_voice]   = 1'b0;
            end
        end
    end

    // State registers with synchronous reset that also aborts a sequence in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            voice_q     <= '0;
            acc_q       <= '0;
            cap_top_q   <= '0;
            rom_addr_q  <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            key_q       <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
`ifdef POLY_SYNTH_ENVELOPE_EN
                gain_q[i]  <= '0;
`endif
            end
        end else begin
            state_q     <= state_d;
            voice_q     <= voice_d;
            acc_q       <= acc_d;
            cap_top_q   <= cap_top_d;
            rom_addr_q  <= rom_addr_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            key_q       <= key_d;
            phase_q     <= phase_d;
            inc_q       <= inc_d;
`ifdef POLY_SYNTH_ENVELOPE_EN
            gain_q      <= gain_d;
`endif
        end
    end

    assign rom_addr  = rom_addr_q;
    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_poly_note_synth.sv
// tb_poly_note_synth
// Bench for poly_note_synth in its default build (unity gain, 4 voices).
// Drives inputs 2 time units after each rising edge; the reference model and
// output comparison run on the falling edge.
module tb_poly_note_synth;

    localparam int NV  = 4;
    localparam int LAT = 2 * NV + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       note_wr;
    logic [1:0] note_voice;
    logic [9:0] note_data;
    logic [1:0] wave_sel;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [9:0] mix_out;
    logic       mix_valid;
    logic       busy;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model state
    int mPhase [NV];
    int mInc   [NV];
    bit mOn    [NV];
    int mCnt   = 0;
    int mAcc   = 0;
    int mCap   = 0;
    int mRom   = 0;
    int mMix   = 0;
    bit mValid = 1'b0;
    bit mReady = 1'b0;
    int baseTable [12] = '{64, 68, 72, 76, 81, 85, 91, 96, 102, 108, 114, 121};

    poly_note_synth dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .note_wr     (note_wr),
        .note_voice  (note_voice),
        .note_data   (note_data),
        .wave_sel    (wave_sel),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Arbitrary wave table standing in for the sine ROM
    function automatic logic [7:0] romValue(input int addr);
        return 8'((addr * 37 + 11) & 255);
    endfunction

    assign rom_data = romValue(int'(rom_addr));

    // Waveform value for a 16-bit phase, straight from the waveform definitions
    function automatic int waveOf(input int sel, input int phase);
        int t;
        t = phase / 256;
        case (sel)
            0:       return int'(romValue(t));
            1:       return (phase >= 32768) ? 0 : 255;
            2:       return t;
            default: return (t < 128) ? 2 * t : 255 - 2 * (t - 128);
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual == expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Advance the model by the rising edge that is about to sample the current inputs
    task automatic modelStep();
        int k;
        int v;
        int s;
        int semi;
        int oct;
        if (reset) begin
            for (int i = 0; i < NV; i++) begin
                mPhase[i] = 0;
                mInc[i]   = 0;
                mOn[i]    = 1'b0;
            end
            mCnt   = 0;
            mAcc   = 0;
            mCap   = 0;
            mRom   = 0;
            mMix   = 0;
            mValid = 1'b0;
            mReady = 1'b1;
            return;
        end
        if (!mReady) begin
            return;
        end
        mValid = 1'b0;
        k = mCnt;
        if (k == 0) begin
            if (sample_tick) begin
                mCnt = 1;
                mAcc = 0;
            end
        end else if (k == LAT) begin
            mMix   = mAcc;
            mValid = 1'b1;
            mCnt   = 0;
        end else begin
            if (k % 2 == 1) begin
                v    = (k - 1) / 2;
                mCap = mPhase[v];
                mRom = mPhase[v] / 256;
            end else begin
                v    = k / 2 - 1;
                s    = mOn[v] ? waveOf(int'(wave_sel), mCap) : 128;
                mAcc = mAcc + s;
                if (mOn[v] && !(note_wr && int'(note_voice) == v)) begin
                    mPhase[v] = (mPhase[v] + mInc[v]) % 65536;
                end
            end
            mCnt = k + 1;
        end
        if (note_wr) begin
            v    = int'(note_voice);
            semi = int'(note_data[3:0]);
            oct  = int'(note_data[6:4]);
            if (note_data[9] && semi <= 11) begin
                if (!mOn[v]) begin
                    mPhase[v] = 0;
                end
                mInc[v] = baseTable[semi] * (1 << oct);
                mOn[v]  = 1'b1;
            end else begin
                mOn[v] = 1'b0;
            end
        end
    endtask

    // Every cycle: compare all outputs with the model, then step the model
    always @(negedge clk) begin
        if (mReady) begin
            checkOutput("busy", int'(busy), (mCnt != 0) ? 1 : 0);
            checkOutput("mix_valid", int'(mix_valid), mValid ? 1 : 0);
            checkOutput("mix_out", int'(mix_out), mMix);
            checkOutput("rom_addr", int'(rom_addr), mRom);
        end
        modelStep();
    end

    // One-cycle note write
    task automatic applyStimulus(input logic [1:0] voice, input logic [9:0] data);
        note_wr    = 1'b1;
        note_voice = voice;
        note_data  = data;
        @(posedge clk);
        #2;
        note_wr = 1'b0;
    endtask

    // One sample request; reports latency, mix, voice0/voice1 fetch addresses and busy cycles
    task automatic runTick(output int lat, output int mix, output int rom1, output int rom3,
                           output int busyCnt);
        bit done;
        lat         = 0;
        mix         = -1;
        rom1        = -1;
        rom3        = -1;
        done        = 1'b0;
        sample_tick = 1'b1;
        @(posedge clk);
        #2;
        sample_tick = 1'b0;
        busyCnt     = int'(busy);
        for (int n = 1; n <= 40 && !done; n++) begin
            @(posedge clk);
            #2;
            busyCnt = busyCnt + int'(busy);
            if (n == 1) rom1 = int'(rom_addr);
            if (n == 3) rom3 = int'(rom_addr);
            if (mix_valid) begin
                lat  = n;
                mix  = int'(mix_out);
                done = 1'b1;
            end
        end
    endtask

    initial begin
        int  lat;
        int  mix;
        int  rom1;
        int  rom3;
        int  busyCnt;
        int  nValid;
        bit  done;

        reset       = 1'b1;
        sample_tick = 1'b0;
        note_wr     = 1'b0;
        note_voice  = '0;
        note_data   = '0;
        wave_sel    = 2'd2;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("reset_rom_addr", int'(rom_addr), 0);
        checkOutput("reset_mix_out", int'(mix_out), 0);
        checkOutput("reset_mix_valid", int'(mix_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);

        // All voices off: four mid-scale contributions
        runTick(lat, mix, rom1, rom3, busyCnt);
        checkOutput("idle_latency", lat, 9);
        checkOutput("idle_mix", mix, 512);
        checkOutput("idle_busy_cycles", busyCnt, 9);

        // Voice0 C octave 0 on saw, five sequences
        applyStimulus(2'd0, 10'h200);
        for (int i = 0; i < 5; i++) begin
            runTick(lat, mix, rom1, rom3, busyCnt);
            checkOutput("saw_latency", lat, 9);
        end
        checkOutput("saw_fifth_mix", mix, 385);
        checkOutput("model_phase0_320", mPhase[0], 320);

        // Voice1 octave 3 semitone 9
        applyStimulus(2'd1, 10'h239);
        runTick(lat, mix, rom1, rom3, busyCnt);
        checkOutput("v1_first_rom_addr0", rom1, 1);
        checkOutput("v1_first_rom_addr1", rom3, 0);
        checkOutput("v1_first_mix", mix, 257);
        checkOutput("model_phase1_864", mPhase[1], 864);
        runTick(lat, mix, rom1, rom3, busyCnt);
        checkOutput("v1_second_rom_addr1", rom3, 3);
        checkOutput("v1_second_mix", mix, 260);

        // Semitone 13 is a key-off: mid-scale contribution, phase frozen
        applyStimulus(2'd0, 10'h20D);
        runTick(lat, mix, rom1, rom3, busyCnt);
        checkOutput("keyoff_mix", mix, 390);
        checkOutput("model_phase0_held", mPhase[0], 448);

        // Off->on clears the phase; retuning a sounding voice keeps it
        applyStimulus(2'd0, 10'h200);
        applyStimulus(2'd1, 10'h200);
        runTick(lat, mix, rom1, rom3, busyCnt);
        checkOutput("restart_rom_addr0", rom1, 0);
        checkOutput("retune_rom_addr1", rom3, 10);
        checkOutput("retune_mix", mix, 266);

        // A second request three cycles into a sequence is dropped
        nValid      = 0;
        sample_tick = 1'b1;
        @(posedge clk);
        #2;
        sample_tick = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #2;
            nValid = nValid + int'(mix_valid);
        end
        sample_tick = 1'b1;
        @(posedge clk);
        #2;
        sample_tick = 1'b0;
        nValid = nValid + int'(mix_valid);
        repeat (22) begin
            @(posedge clk);
            #2;
            nValid = nValid + int'(mix_valid);
        end
        checkOutput("retick_valid_count", nValid, 1);

        // Reset on the fourth edge of a sequence aborts it
        sample_tick = 1'b1;
        @(posedge clk);
        #2;
        sample_tick = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        checkOutput("abort_rom_addr", int'(rom_addr), 0);
        checkOutput("abort_mix_out", int'(mix_out), 0);
        checkOutput("abort_mix_valid", int'(mix_valid), 0);
        checkOutput("abort_busy", int'(busy), 0);
        nValid = 0;
        repeat (20) begin
            @(posedge clk);
            #2;
            nValid = nValid + int'(mix_valid);
        end
        checkOutput("abort_valid_count", nValid, 0);

        // A retune landing on the voice's own accumulate step drops that step
        applyStimulus(2'd0, 10'h270);
        runTick(lat, mix, rom1, rom3, busyCnt);
        checkOutput("coinc_setup_latency", lat, 9);
        sample_tick = 1'b1;
        @(posedge clk);
        #2;
        sample_tick = 1'b0;
        @(posedge clk);
        #2;
        note_wr    = 1'b1;
        note_voice = 2'd0;
        note_data  = 10'h270;
        @(posedge clk);
        #2;
        note_wr = 1'b0;
        done    = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(posedge clk);
            #2;
            if (mix_valid) done = 1'b1;
        end
        checkOutput("coinc_sequence_done", int'(done), 1);
        checkOutput("model_phase0_kept", mPhase[0], 8192);
        runTick(lat, mix, rom1, rom3, busyCnt);
        checkOutput("coinc_rom_addr0", rom1, 32);
        checkOutput("coinc_mix", mix, 416);

        // Random traffic: notes, waveforms, requests and occasional resets at any time
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 599) == 0);
            sample_tick = ($urandom_range(0, 5) == 0);
            note_wr     = ($urandom_range(0, 7) == 0);
            note_voice  = 2'($urandom_range(0, 3));
            note_data   = {($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 19) == 0) begin
                wave_sel = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            #2;
        end
        reset       = 1'b0;
        sample_tick = 1'b0;
        note_wr     = 1'b0;
        repeat (20) @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
